// File: rtl/ftf_encoder_seq_pkg.sv
// Shared definitions for the forbidden-transition-free Fibonacci encoder family:
// state encoding, width limit and the constant functions used to size and weight codewords.
package ftf_encoder_seq_pkg;

  localparam int FTF_MAX_CODE_W = 60;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } ftf_state_e;

  // FIB(0)=0, FIB(1)=FIB(2)=1; 64 bits covers FIB(62) for the widest codeword.
  function automatic longint unsigned fib(input int k);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int clog2(input longint unsigned v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ftf_pair_step.sv
// Combinational resolution of one codeword bit pair (hi=2p+1, lo=2p) from the running remainder.
// Thresholds and weights are constant tables indexed by the pair number.
module ftf_pair_step
  import ftf_encoder_seq_pkg::*;
#(
  parameter int CODE_W = 28,
  parameter int DATA_W = 20,
  localparam int NUM_PAIRS = CODE_W / 2,
  localparam int PW = $clog2(NUM_PAIRS)
) (
  input  logic [DATA_W-1:0] r,
  input  logic [PW-1:0]     p,
  output logic [1:0]        bits,
  output logic [DATA_W-1:0] r2
);

  logic [DATA_W-1:0] hi_cmp [NUM_PAIRS];
  logic [DATA_W-1:0] hi_wt  [NUM_PAIRS];
  logic [DATA_W-1:0] lo_wt  [NUM_PAIRS];
  logic [DATA_W-1:0] r1;

  // The hi bit is set against FIB(2p+3) but subtracts only its own weight FIB(2p+2),
  // which forces the lo bit of the same pair whenever hi is set.
  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_tab
    localparam logic [DATA_W-1:0] HI_CMP = DATA_W'(fib(2 * g + 3));
    localparam logic [DATA_W-1:0] HI_WT  = DATA_W'(fib(2 * g + 2));
    localparam logic [DATA_W-1:0] LO_WT  = DATA_W'(fib(2 * g + 1));
    assign hi_cmp[g] = HI_CMP;
    assign hi_wt[g]  = HI_WT;
    assign lo_wt[g]  = LO_WT;
  end

  always_comb begin
    bits = 2'b00;
    r1   = r;
    if (r >= hi_cmp[p]) begin
      bits[1] = 1'b1;
      r1      = r - hi_wt[p];
    end
    r2 = r1;
    if (r1 >= lo_wt[p]) begin
      bits[0] = 1'b1;
      r2      = r1 - lo_wt[p];
    end
  end

endmodule

// File: rtl/ftf_encoder_seq.sv
// Sequential FTF Fibonacci encoder: accepts a binary word, resolves one bit pair per clock
// from the top pair down, and presents the registered codeword with an out-of-range flag.
module ftf_encoder_seq
  import ftf_encoder_seq_pkg::*;
#(
  parameter int CODE_W = 28,
  // Wide enough to carry FIB(CODE_W+2) itself, so the first out-of-range value is representable.
  localparam int DATA_W = clog2(fib(CODE_W + 2) + 64'd1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              out_err,
  output ftf_state_e        fsm_state
);

  localparam int NUM_PAIRS = CODE_W / 2;
  localparam int PW = $clog2(NUM_PAIRS);
  localparam logic [DATA_W-1:0] FIB_LIMIT = DATA_W'(fib(CODE_W + 2));
  localparam logic [PW-1:0] P_TOP = PW'(NUM_PAIRS - 1);

  if ((CODE_W % 2) != 0 || CODE_W < 4 || CODE_W > FTF_MAX_CODE_W) begin : g_bad_code_w
    $error("ftf_encoder_seq: CODE_W must be even and within 4..%0d", FTF_MAX_CODE_W);
  end

  ftf_state_e        state;
  ftf_state_e        state_next;
  logic              accept;
  logic              over;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] r_next;
  logic [PW-1:0]     p;
  logic [1:0]        pair_bits;

  ftf_pair_step #(
    .CODE_W (CODE_W),
    .DATA_W (DATA_W)
  ) u_step (
    .r    (r),
    .p    (p),
    .bits (pair_bits),
    .r2   (r_next)
  );

  assign over      = (datain >= FIB_LIMIT);
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A transfer happens on a rising edge where valid and ready are both high; a producer holds
  // valid and its data until that edge, and ready may depend on the partner's valid/ready.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (p == '0) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = S_BUSY;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r       <= '0;
      p       <= '0;
      codeout <= '0;
      out_err <= 1'b0;
    end else if (accept) begin
      r       <= over ? (FIB_LIMIT - 1'b1) : datain;
      p       <= P_TOP;
      codeout <= '0;
      out_err <= over;
    end else if (state == S_BUSY) begin
      r                      <= r_next;
      codeout[{p, 1'b0} +: 2] <= pair_bits;
      if (p != '0) p <= p - 1'b1;
    end
  end

  // Greedy descent keeps r below FIB(2p+4) before each pair, so nothing is left after pair 0.
  assert property (@(posedge clock) disable iff (reset)
    (state == S_BUSY && p == '0) |-> (r_next == '0))
  else $error("ftf_encoder_seq: nonzero remainder after final pair");

endmodule
